// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and router FSM state encodings.
package axi4_lite_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    W_IDLE,
    W_REQ,
    W_RESP,
    W_ERR_REQ,
    W_ERR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RESP,
    R_ERR
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_onehot_to_idx.sv
// Priority one-hot to binary index; the lowest set bit wins, hit flags any bit set.
module axi4_lite_onehot_to_idx #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     sel,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (sel[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_resp_router.sv
// Master-side AXI4-Lite request demux / response mux with internal DECERR for unmapped addresses.
module axi4_lite_resp_router
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLAVE_NUM  = 2,
  parameter int unsigned IDX_W      = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SLAVE_NUM-1:0]                 aw_slave_sel,
  input  logic [SLAVE_NUM-1:0]                 ar_slave_sel,
  input  logic                                 m_awvalid,
  input  logic                                 m_wvalid,
  input  logic                                 m_bready,
  input  logic                                 m_arvalid,
  input  logic                                 m_rready,
  output logic                                 m_awready,
  output logic                                 m_wready,
  output logic                                 m_bvalid,
  output logic                                 m_arready,
  output logic                                 m_rvalid,
  output logic [1:0]                           m_bresp,
  output logic [1:0]                           m_rresp,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [SLAVE_NUM-1:0]                 s_awvalid,
  output logic [SLAVE_NUM-1:0]                 s_wvalid,
  output logic [SLAVE_NUM-1:0]                 s_bready,
  output logic [SLAVE_NUM-1:0]                 s_arvalid,
  output logic [SLAVE_NUM-1:0]                 s_rready,
  input  logic [SLAVE_NUM-1:0]                 s_awready,
  input  logic [SLAVE_NUM-1:0]                 s_wready,
  input  logic [SLAVE_NUM-1:0]                 s_bvalid,
  input  logic [SLAVE_NUM-1:0]                 s_arready,
  input  logic [SLAVE_NUM-1:0]                 s_rvalid,
  input  logic [SLAVE_NUM-1:0][1:0]            s_bresp,
  input  logic [SLAVE_NUM-1:0][1:0]            s_rresp,
  input  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0] s_rdata
);

  wr_state_t        w_state, w_state_d;
  rd_state_t        r_state, r_state_d;
  logic [IDX_W-1:0] w_idx, w_idx_d, r_idx, r_idx_d;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_hit, ar_hit;
  logic             aw_done, aw_done_d, w_done, w_done_d, ar_done, ar_done_d;
  logic             aw_hs, w_hs;

  axi4_lite_onehot_to_idx #(.N(SLAVE_NUM), .IDX_W(IDX_W)) u_aw_dec (
    .sel (aw_slave_sel),
    .idx (aw_idx),
    .hit (aw_hit)
  );

  axi4_lite_onehot_to_idx #(.N(SLAVE_NUM), .IDX_W(IDX_W)) u_ar_dec (
    .sel (ar_slave_sel),
    .idx (ar_idx),
    .hit (ar_hit)
  );

  // State, latched slave index and per-channel completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_idx   <= '0;
      r_idx   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      w_idx   <= w_idx_d;
      r_idx   <= r_idx_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
      ar_done <= ar_done_d;
    end
  end

  // Write path: AW/W steering, B return, DECERR termination of unmapped writes.
  always_comb begin
    w_state_d = w_state;
    w_idx_d   = w_idx;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = RESP_OKAY;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    unique case (w_state)
      W_IDLE: begin
        if (m_awvalid) begin
          w_idx_d   = aw_idx;
          w_state_d = aw_hit ? W_REQ : W_ERR_REQ;
        end
      end
      W_REQ: begin
        s_awvalid[w_idx] = m_awvalid & ~aw_done;
        m_awready        = s_awready[w_idx] & ~aw_done;
        s_wvalid[w_idx]  = m_wvalid & ~w_done;
        m_wready         = s_wready[w_idx] & ~w_done;
        aw_hs            = m_awvalid & s_awready[w_idx] & ~aw_done;
        w_hs             = m_wvalid & s_wready[w_idx] & ~w_done;
        aw_done_d        = aw_done | aw_hs;
        w_done_d         = w_done | w_hs;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_bvalid        = s_bvalid[w_idx];
        s_bready[w_idx] = m_bready;
        if (s_bvalid[w_idx]) m_bresp = s_bresp[w_idx];
        if (s_bvalid[w_idx] && m_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      W_ERR_REQ: begin
        m_awready = ~aw_done;
        m_wready  = ~w_done;
        aw_done_d = aw_done | m_awvalid;
        w_done_d  = w_done | m_wvalid;
        if (aw_done_d && w_done_d) w_state_d = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        m_bvalid = 1'b1;
        m_bresp  = RESP_DECERR;
        if (m_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path: AR steering, R return, DECERR termination of unmapped reads.
  always_comb begin
    r_state_d = r_state;
    r_idx_d   = r_idx;
    ar_done_d = ar_done;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rresp   = RESP_OKAY;
    m_rdata   = '0;
    s_arvalid = '0;
    s_rready  = '0;
    unique case (r_state)
      R_IDLE: begin
        if (m_arvalid) begin
          r_idx_d   = ar_idx;
          r_state_d = ar_hit ? R_REQ : R_ERR;
        end
      end
      R_REQ: begin
        s_arvalid[r_idx] = m_arvalid;
        m_arready        = s_arready[r_idx];
        if (m_arvalid && s_arready[r_idx]) r_state_d = R_RESP;
      end
      R_RESP: begin
        m_rvalid        = s_rvalid[r_idx];
        s_rready[r_idx] = m_rready;
        if (s_rvalid[r_idx]) begin
          m_rresp = s_rresp[r_idx];
          m_rdata = s_rdata[r_idx];
        end
        if (s_rvalid[r_idx] && m_rready) r_state_d = R_IDLE;
      end
      R_ERR: begin
        // ar_done separates the AR acceptance cycle from the DECERR data beat.
        if (!ar_done) begin
          m_arready = 1'b1;
          if (m_arvalid) ar_done_d = 1'b1;
        end else begin
          m_rvalid = 1'b1;
          m_rresp  = RESP_DECERR;
          if (m_rready) begin
            ar_done_d = 1'b0;
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_resp_router.sv
// Table-driven bench with response scoreboard for axi4_lite_resp_router (2 slaves, 32-bit data).
module tb_axi4_lite_resp_router;

  logic             clk, rst_n;
  logic [1:0]       aw_slave_sel, ar_slave_sel;
  logic             m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic             m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]       m_bresp, m_rresp;
  logic [31:0]      m_rdata;
  logic [1:0]       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0]       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][1:0]  s_bresp, s_rresp;
  logic [1:0][31:0] s_rdata;
  logic [50:0]      outs;

  assign outs = {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_bresp, m_rresp, m_rdata,
                 s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};

  axi4_lite_resp_router #(.DATA_WIDTH(32), .SLAVE_NUM(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_slave_sel(aw_slave_sel), .ar_slave_sel(ar_slave_sel),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready),
    .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_rready(s_rready),
    .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [1:0]  sel;
    int          lag;       // W delay after AW (writes)
    int          slat;      // cycles before the slave raises ready
    int          hold;      // cycles the master withholds B/R ready
    logic [1:0]  rsp;       // response driven by the selected slave
    logic [31:0] data;      // rdata driven by the selected slave
    logic [1:0]  exp_rsp;
    logic [31:0] exp_data;
    int          exp_acc;   // cycle of AW/AR acceptance
    int          exp_wacc;  // cycle of W acceptance
  } vec_t;

  typedef struct {
    logic [1:0]  rsp;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[9];
  exp_t wq[$];
  exp_t rq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    aw_slave_sel = '0; ar_slave_sel = '0;
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0; m_arvalid = 1'b0; m_rready = 1'b0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_arready = '0; s_rvalid = '0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic run_write(input vec_t v);
    logic [1:0] oh;
    int cnt, aw_cyc, w_cyc, b_cyc, rdy_cnt, vcnt, last;
    bit aw_ok, w_ok, b_ok, bad;
    exp_t e;
    oh = v.sel & (~v.sel + 2'b01);
    e.rsp = v.exp_rsp; e.data = 32'h0;
    wq.push_back(e);
    cnt = 0; aw_cyc = -1; w_cyc = -1; b_cyc = -1; rdy_cnt = 0; vcnt = 0;
    aw_ok = 1'b0; w_ok = 1'b0; b_ok = 1'b0; bad = 1'b0;
    while (!b_ok && cnt < 40) begin
      @(negedge clk);
      idle_inputs();
      aw_slave_sel = v.sel;
      m_awvalid = !aw_ok;
      m_wvalid  = !w_ok && (cnt >= v.lag);
      s_awready = (cnt >= v.slat) ? oh : 2'b00;
      s_wready  = (cnt >= v.slat) ? oh : 2'b00;
      s_bvalid  = (aw_ok && w_ok) ? oh : 2'b00;
      for (int j = 0; j < 2; j++) s_bresp[j] = oh[j] ? v.rsp : ~v.rsp;
      m_bready = (vcnt >= v.hold);
      #1;
      if (m_awready) rdy_cnt++;
      if (((s_awvalid | s_wvalid | s_bready | s_arvalid | s_rready) & ~oh) != 2'b00) bad = 1'b1;
      if (!m_bvalid && m_bresp != 2'b00) bad = 1'b1;
      if (m_awvalid && m_awready) begin aw_ok = 1'b1; aw_cyc = cnt; end
      if (m_wvalid && m_wready) begin w_ok = 1'b1; w_cyc = cnt; end
      if (m_bvalid) begin
        if (b_cyc < 0) b_cyc = cnt;
        if (wq.size() == 0) begin
          chk("b_unexpected", 64'(m_bvalid), 64'(0));
          b_ok = 1'b1;
        end else if (m_bready) begin
          e = wq.pop_front();
          chk("wr_bresp", 64'(m_bresp), 64'(e.rsp));
          b_ok = 1'b1;
        end else begin
          vcnt++;
          if (m_bresp !== wq[0].rsp) bad = 1'b1;
        end
      end
      cnt++;
    end
    wq.delete();
    last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
    chk("wr_b_done", 64'(b_ok), 64'(1));
    chk("wr_aw_cycle", 64'(aw_cyc), 64'(v.exp_acc));
    chk("wr_w_cycle", 64'(w_cyc), 64'(v.exp_wacc));
    chk("wr_b_latency", 64'(b_cyc - last), 64'(1));
    chk("wr_awready_pulse", 64'(rdy_cnt), 64'(1));
    chk("wr_routing", 64'(bad), 64'(0));
  endtask

  task automatic run_read(input vec_t v);
    logic [1:0] oh;
    int cnt, ar_cyc, r_cyc, rdy_cnt, vcnt;
    bit ar_ok, r_ok, bad;
    exp_t e;
    oh = v.sel & (~v.sel + 2'b01);
    e.rsp = v.exp_rsp; e.data = v.exp_data;
    rq.push_back(e);
    cnt = 0; ar_cyc = -1; r_cyc = -1; rdy_cnt = 0; vcnt = 0;
    ar_ok = 1'b0; r_ok = 1'b0; bad = 1'b0;
    while (!r_ok && cnt < 40) begin
      @(negedge clk);
      idle_inputs();
      ar_slave_sel = v.sel;
      m_arvalid = !ar_ok;
      s_arready = (cnt >= v.slat) ? oh : 2'b00;
      s_rvalid  = ar_ok ? oh : 2'b00;
      for (int j = 0; j < 2; j++) begin
        s_rresp[j] = oh[j] ? v.rsp : ~v.rsp;
        s_rdata[j] = oh[j] ? v.data : ~v.data;
      end
      m_rready = (vcnt >= v.hold);
      #1;
      if (m_arready) rdy_cnt++;
      if (((s_awvalid | s_wvalid | s_bready | s_arvalid | s_rready) & ~oh) != 2'b00) bad = 1'b1;
      if (!m_rvalid && (m_rresp != 2'b00 || m_rdata != 32'h0)) bad = 1'b1;
      if (m_arvalid && m_arready) begin ar_ok = 1'b1; ar_cyc = cnt; end
      if (m_rvalid) begin
        if (r_cyc < 0) r_cyc = cnt;
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'(m_rvalid), 64'(0));
          r_ok = 1'b1;
        end else if (m_rready) begin
          e = rq.pop_front();
          chk("rd_rresp", 64'(m_rresp), 64'(e.rsp));
          chk("rd_rdata", 64'(m_rdata), 64'(e.data));
          r_ok = 1'b1;
        end else begin
          vcnt++;
          if (m_rresp !== rq[0].rsp || m_rdata !== rq[0].data) bad = 1'b1;
        end
      end
      cnt++;
    end
    rq.delete();
    chk("rd_r_done", 64'(r_ok), 64'(1));
    chk("rd_ar_cycle", 64'(ar_cyc), 64'(v.exp_acc));
    chk("rd_r_latency", 64'(r_cyc - ar_cyc), 64'(1));
    chk("rd_arready_pulse", 64'(rdy_cnt), 64'(1));
    chk("rd_routing_stable", 64'(bad), 64'(0));
  endtask

  initial begin
    exp_t e;
    //         rd sel    lag slat hold rsp    data          exp_rsp exp_data      acc wacc
    vecs[0] = '{0, 2'b10, 0, 2, 0, 2'b00, 32'h0,        2'b00, 32'h0,        2, 2};
    vecs[1] = '{0, 2'b01, 3, 0, 2, 2'b10, 32'h0,        2'b10, 32'h0,        1, 3};
    vecs[2] = '{0, 2'b00, 4, 0, 0, 2'b00, 32'h0,        2'b11, 32'h0,        1, 4};
    vecs[3] = '{0, 2'b11, 0, 1, 0, 2'b10, 32'h0,        2'b10, 32'h0,        1, 1};
    vecs[4] = '{1, 2'b01, 0, 0, 3, 2'b00, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1, 0};
    vecs[5] = '{1, 2'b10, 0, 3, 0, 2'b10, 32'h12345678, 2'b10, 32'h12345678, 3, 0};
    vecs[6] = '{1, 2'b00, 0, 0, 1, 2'b00, 32'hAAAA5555, 2'b11, 32'h0,        1, 0};
    vecs[7] = '{1, 2'b11, 0, 2, 0, 2'b00, 32'h0F0F0F0F, 2'b00, 32'h0F0F0F0F, 2, 0};
    vecs[8] = '{0, 2'b00, 0, 0, 2, 2'b00, 32'h0,        2'b11, 32'h0,        1, 1};

    // Reset state: outputs quiet even with master requests pending.
    rst_n = 1'b0;
    idle_inputs();
    m_awvalid = 1'b1; m_arvalid = 1'b1; aw_slave_sel = 2'b01; ar_slave_sel = 2'b10;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 64'(outs), 64'(0));
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_rd) run_read(vecs[i]);
      else run_write(vecs[i]);
    end

    // Concurrent write to slave 0 and read to slave 1; R returns before B.
    @(negedge clk);
    idle_inputs();
    aw_slave_sel = 2'b01; ar_slave_sel = 2'b10;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_arvalid = 1'b1;
    s_awready = 2'b01; s_wready = 2'b01; s_arready = 2'b10;
    e.rsp = 2'b10; e.data = 32'h0;        wq.push_back(e);
    e.rsp = 2'b00; e.data = 32'hCAFEF00D; rq.push_back(e);
    @(negedge clk);
    #1;
    chk("conc_accept", 64'({m_awready, m_wready, m_arready}), 64'(3'b111));
    chk("conc_route", 64'({s_awvalid, s_wvalid, s_arvalid}), 64'(6'b01_01_10));
    @(negedge clk);
    idle_inputs();
    s_rvalid = 2'b10; s_rdata[1] = 32'hCAFEF00D; s_rdata[0] = 32'h11111111;
    s_rresp[1] = 2'b00; s_rresp[0] = 2'b10; s_bresp[0] = 2'b10;
    m_rready = 1'b1; m_bready = 1'b1;
    #1;
    e = rq.pop_front();
    chk("conc_r", 64'({m_rvalid, m_rresp, m_rdata}), 64'({1'b1, e.rsp, e.data}));
    chk("conc_b_wait", 64'(m_bvalid), 64'(0));
    @(negedge clk);
    idle_inputs();
    s_bvalid = 2'b01; s_bresp[0] = 2'b10; s_bresp[1] = 2'b01;
    m_rready = 1'b1; m_bready = 1'b1;
    #1;
    e = wq.pop_front();
    chk("conc_b", 64'({m_bvalid, m_bresp}), 64'({1'b1, e.rsp}));
    chk("conc_r_done", 64'(m_rvalid), 64'(0));
    @(negedge clk);
    idle_inputs();
    #1 chk("conc_idle", 64'(outs), 64'(0));

    // Asynchronous reset while waiting in W_RESP drops the pending response.
    @(negedge clk);
    idle_inputs();
    aw_slave_sel = 2'b01; m_awvalid = 1'b1; m_wvalid = 1'b1;
    s_awready = 2'b01; s_wready = 2'b01;
    @(negedge clk);
    #1 chk("rst_seq_accept", 64'({m_awready, m_wready}), 64'(2'b11));
    @(negedge clk);
    idle_inputs();
    s_bvalid = 2'b01; s_bresp[0] = 2'b10;
    #1 chk("rst_seq_bvalid", 64'({m_bvalid, m_bresp, s_bready}), 64'(5'b110_00));
    rst_n = 1'b0;
    #1 chk("rst_async_outs", 64'(outs), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("post_rst_bvalid", 64'({m_bvalid, s_bready}), 64'(0));
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
